// File: rtl/clock_divider_multi_pkg.sv
// Shared helpers for the multi-channel clock divider.
// Latency: n/a (package only).
// Backpressure: n/a.
package clock_divider_multi_pkg;

    // Effective divisor: a programmed 0 behaves exactly like 1.
    // Operates on 32-bit values; divider widths up to 32 bits are supported.
    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, active/pending divisor, 50% toggle clock and tick strobe.
// Latency: outputs registered; tick/clk_out update on the E-th enabled edge of each period.
// Backpressure: none; en freezes the phase, divisor changes wait for a period boundary.
//
// Ports: clk_in/rst_n clock and async active-low reset; en count enable;
//        div_load/div_i divisor capture; sync_clear phase restart;
//        clk_out divided clock; tick one-cycle boundary strobe.
module clock_divider_channel
    import clock_divider_multi_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_i,
    input  logic             sync_clear,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pend;
    logic             r_pend_vld;
    logic             r_clk;
    logic             r_tick;

    logic [WIDTH-1:0] w_eff;
    logic [WIDTH-1:0] w_next_div;
    logic             w_last;

    always_comb begin
        w_eff      = WIDTH'(eff_div(32'(r_div)));
        // >= rather than == so a divisor shrunk while the channel is frozen
        // mid-period ends that period on the next enabled edge instead of wrapping.
        w_last     = (r_cnt >= (w_eff - WIDTH'(1)));
        // Divisor taken at a boundary: a load on that very edge beats the pending value.
        w_next_div = div_load ? div_i : (r_pend_vld ? r_pend : r_div);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_div      <= WIDTH'(DEFAULT_DIV);
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
        end else if (sync_clear) begin
            r_cnt      <= '0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
            r_div      <= w_next_div;
            r_pend_vld <= 1'b0;
        end else if (!en) begin
            r_tick <= 1'b0;
            // Frozen channel: capture now, apply on the following edge.
            if (div_load) begin
                r_pend     <= div_i;
                r_pend_vld <= 1'b1;
            end else if (r_pend_vld) begin
                r_div      <= r_pend;
                r_pend_vld <= 1'b0;
            end
        end else if (w_last) begin
            r_cnt      <= '0;
            r_tick     <= 1'b1;
            r_clk      <= ~r_clk;
            r_div      <= w_next_div;
            r_pend_vld <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + WIDTH'(1);
            r_tick <= 1'b0;
            if (div_load) begin
                r_pend     <= div_i;
                r_pend_vld <= 1'b1;
            end
        end
    end

    assign clk_out = r_clk;
    assign tick    = r_tick;

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent runtime-programmable clock dividers sharing one system clock.
// Latency: outputs registered, no input-to-output combinational path.
// Backpressure: none; per-channel en freezes phase, sync_clear restarts all channels together.
//
// Ports: clk_in, rst_n (async active-low); en/div_load per channel; div_i packed
//        divisors (channel c at [c*WIDTH +: WIDTH]); sync_clear; clk_out/tick per channel.
module clock_divider_multi
    import clock_divider_multi_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 1
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*WIDTH-1:0] div_i,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic                    sync_clear,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clock_divider_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_in     (clk_in),
            .rst_n      (rst_n),
            .en         (en[c]),
            .div_load   (div_load[c]),
            .div_i      (div_i[c*WIDTH +: WIDTH]),
            .sync_clear (sync_clear),
            .clk_out    (clk_out[c]),
            .tick       (tick[c])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
module tb_clock_divider_multi;
    localparam int NCH = 4;
    localparam int W   = 16;

    logic              clk_in = 1'b0;
    logic              rst_n = 1'b1;
    logic              sync_clear = 1'b0;
    logic [NCH-1:0]    en = '0;
    logic [NCH-1:0]    div_load = '0;
    logic [NCH*W-1:0]  div_i = '0;
    logic [NCH-1:0]    clk_out;
    logic [NCH-1:0]    tick;

    int n_cmp  = 0;
    int n_fail = 0;

    clock_divider_multi #(.NUM_CH(NCH), .WIDTH(W), .DEFAULT_DIV(1)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .en         (en),
        .div_i      (div_i),
        .div_load   (div_load),
        .sync_clear (sync_clear),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: per channel, a position within the current period,
    // the divisor governing it, and an optional queued divisor.
    int          m_pos  [NCH];
    int          m_div  [NCH];
    int          m_pend [NCH];
    bit          m_has  [NCH];
    logic [NCH-1:0] m_clk;
    logic [NCH-1:0] m_tick;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_pos[c] = 0; m_div[c] = 1; m_pend[c] = 0; m_has[c] = 0;
        end
        m_clk = '0; m_tick = '0;
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            int nv;
            int boundary_div;
            nv = int'(div_i[c*W +: W]);
            boundary_div = div_load[c] ? nv : (m_has[c] ? m_pend[c] : m_div[c]);
            if (sync_clear) begin
                m_pos[c] = 0; m_clk[c] = 1'b0; m_tick[c] = 1'b0;
                m_div[c] = boundary_div; m_has[c] = 0;
            end else if (!en[c]) begin
                m_tick[c] = 1'b0;
                if (div_load[c]) begin
                    m_pend[c] = nv; m_has[c] = 1;
                end else if (m_has[c]) begin
                    m_div[c] = m_pend[c]; m_has[c] = 0;
                end
            end else if (m_pos[c] + 1 >= eff(m_div[c])) begin
                // This enabled edge completes the period.
                m_pos[c] = 0; m_tick[c] = 1'b1; m_clk[c] = ~m_clk[c];
                m_div[c] = boundary_div; m_has[c] = 0;
            end else begin
                m_pos[c] = m_pos[c] + 1; m_tick[c] = 1'b0;
                if (div_load[c]) begin
                    m_pend[c] = nv; m_has[c] = 1;
                end
            end
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_div(input int c, input int v);
        div_i[c*W +: W] = W'(v);
    endtask

    // One clock edge: model advances on the same edge, outputs compared 1ns later.
    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        check("model_tick", int'(tick), int'(m_tick));
        check("model_clk_out", int'(clk_out), int'(m_clk));
    endtask

    task automatic ticks_until(input int c, input int maxn, output int n);
        n = 0;
        forever begin
            step();
            n++;
            if (tick[c]) break;
            if (n >= maxn) begin
                n = -1;
                break;
            end
        end
    endtask

    task automatic clear_with_load(input logic [NCH-1:0] mask);
        en = '0; div_load = mask; sync_clear = 1'b1;
        step();
        sync_clear = 1'b0; div_load = '0;
    endtask

    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] ld;
        int             dv;
        logic           sc;
        logic [NCH-1:0] exp_tick;
        logic [NCH-1:0] exp_clk;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n, f1, f2;

        tbl[0]  = '{4'b0001, 4'b0010, 4, 1'b0, 4'b0001, 4'b0001};
        tbl[1]  = '{4'b0001, 4'b0000, 4, 1'b0, 4'b0001, 4'b0000};
        tbl[2]  = '{4'b0011, 4'b0000, 4, 1'b0, 4'b0001, 4'b0001};
        tbl[3]  = '{4'b0011, 4'b0000, 4, 1'b0, 4'b0001, 4'b0000};
        tbl[4]  = '{4'b0011, 4'b0000, 4, 1'b0, 4'b0001, 4'b0001};
        tbl[5]  = '{4'b0011, 4'b0000, 4, 1'b0, 4'b0011, 4'b0010};
        tbl[6]  = '{4'b0011, 4'b0000, 4, 1'b0, 4'b0001, 4'b0011};
        tbl[7]  = '{4'b0011, 4'b0000, 4, 1'b0, 4'b0001, 4'b0010};
        tbl[8]  = '{4'b0011, 4'b0000, 4, 1'b0, 4'b0001, 4'b0011};
        tbl[9]  = '{4'b0011, 4'b0000, 4, 1'b0, 4'b0011, 4'b0000};
        tbl[10] = '{4'b0010, 4'b0000, 4, 1'b0, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0010, 4'b0000, 4, 1'b1, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0011, 4'b0000, 4, 1'b0, 4'b0001, 4'b0001};

        // Reset state
        #2 rst_n = 1'b0;
        model_reset();
        #2;
        check("reset_clk_out", int'(clk_out), 0);
        check("reset_tick", int'(tick), 0);
        #10 rst_n = 1'b1;

        // Directed table: ch0 at default divisor, ch1 loaded to 4 while frozen
        for (int i = 0; i < 13; i++) begin
            en = tbl[i].en; div_load = tbl[i].ld; sync_clear = tbl[i].sc;
            for (int c = 0; c < NCH; c++) set_div(c, tbl[i].dv);
            step();
            check($sformatf("tbl%0d_tick", i), int'(tick), int'(tbl[i].exp_tick));
            check($sformatf("tbl%0d_clk_out", i), int'(clk_out), int'(tbl[i].exp_clk));
        end
        div_load = '0; sync_clear = 1'b0;

        // ch2: D=5, load 2 after first count -> period finishes at 5, then 2
        set_div(2, 5); clear_with_load(4'b0100);
        en = 4'b0100;
        step();
        set_div(2, 2); div_load = 4'b0100;
        step();
        div_load = '0;
        ticks_until(2, 20, n); check("ch2_old_period_rest", n, 3);
        ticks_until(2, 20, n); check("ch2_new_period", n, 2);
        ticks_until(2, 20, n); check("ch2_new_period_2", n, 2);

        // ch2: two loads in one period, the later one (3) wins
        set_div(2, 5); clear_with_load(4'b0100);
        en = 4'b0100;
        set_div(2, 2); div_load = 4'b0100; step();
        set_div(2, 3); step();
        div_load = '0;
        ticks_until(2, 20, n); check("ch2_last_load_rest", n, 3);
        ticks_until(2, 20, n); check("ch2_last_load_wins", n, 3);

        // ch3: D=0 behaves as D=1
        set_div(3, 0); clear_with_load(4'b1000);
        en = 4'b1000;
        for (int k = 0; k < 6; k++) begin
            step();
            check("ch3_d0_tick", int'(tick[3]), 1);
            check("ch3_d0_clk", int'(clk_out[3]), (k + 1) % 2);
        end

        // ch0: D=6, freeze at count 2 of the second period, resume
        set_div(0, 6); clear_with_load(4'b0001);
        en = 4'b0001;
        repeat (8) step();
        en = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            step();
            check("ch0_frozen_tick", int'(tick[0]), 0);
            check("ch0_frozen_clk", int'(clk_out[0]), 1);
        end
        en = 4'b0001;
        ticks_until(0, 20, n); check("ch0_resume_to_tick", n, 4);

        // sync_clear realigns D=3 and D=7 channels from mixed phases
        set_div(1, 3); set_div(2, 7); clear_with_load(4'b0110);
        en = 4'b0110;
        repeat (5) step();
        sync_clear = 1'b1; step(); sync_clear = 1'b0;
        check("sc_clk_out", int'(clk_out), 0);
        check("sc_tick", int'(tick), 0);
        f1 = -1; f2 = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (tick[1] && f1 < 0) f1 = k;
            if (tick[2] && f2 < 0) f2 = k;
        end
        check("sc_first_tick_d3", f1, 3);
        check("sc_first_tick_d7", f2, 7);

        // Async reset mid-period; ch0 still at D=6 returns to default 1
        en = 4'b1111;
        repeat (3) step();
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_clk_out", int'(clk_out), 0);
        check("arst_tick", int'(tick), 0);
        #3 rst_n = 1'b1;
        en = 4'b0001;
        step();
        check("arst_default_div_tick", int'(tick[0]), 1);
        step();
        check("arst_default_div_tick2", int'(tick[0]), 1);

        // Randomised traffic against the model
        for (int k = 0; k < 1500; k++) begin
            en = NCH'($urandom);
            div_load = ($urandom_range(3) == 0) ? NCH'($urandom) : '0;
            for (int c = 0; c < NCH; c++) set_div(c, int'($urandom_range(8)));
            sync_clear = ($urandom_range(63) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
